cpu_bus_arbiter: RTL and testbench

Merges the CPU's instruction bus (cpui_*) and data bus (cpud_*) onto a single memory port. It sits directly downstream of the `cpu` top level and upstream of the memory/peripheral fabric. It captures one-cycle request pulses from each CPU bus and serialises them as single outstanding memory transactions. Each memory response is routed back to the bus that requested it as a one-cycle ack.

---
 rtl/cpu_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data buses onto one memory port with a single
// outstanding transaction; each memory ack is routed back to the requesting bus.
//
// state  | meaning
// IDLE   | nothing in flight; any pending or arriving request is issued at once
// BUSY_D | data transaction in flight, waiting for mem_ack
// BUSY_I | instruction fetch in flight, waiting for mem_ack
module cpu_bus_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpud_request,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_byte_enable,
    input  logic [31:0] cpud_wdata,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        protocol_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    state_t state, state_next;

    logic        d_pend;
    logic [31:0] d_slot_addr;
    logic        d_slot_write;
    logic [3:0]  d_slot_be;
    logic [31:0] d_slot_wdata;
    logic        i_pend;
    logic [31:0] i_slot_addr;
    logic        last_grant_d;

    logic d_dup, i_dup, d_new, i_new, d_avail, i_avail;
    logic can_issue, issue_d, issue_i, ack_d, ack_i;

    // A bus's slot becomes free on the very edge its ack is taken.
    assign d_dup   = cpud_request && (d_pend || (state == BUSY_D && !mem_ack));
    assign i_dup   = cpui_request && (i_pend || (state == BUSY_I && !mem_ack));
    assign d_new   = cpud_request && !d_dup;
    assign i_new   = cpui_request && !i_dup;
    assign d_avail = d_pend || d_new;
    assign i_avail = i_pend || i_new;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_avail && i_avail)
                    state_next = (DATA_PRIORITY || !last_grant_d) ? BUSY_D : BUSY_I;
                else if (d_avail)
                    state_next = BUSY_D;
                else if (i_avail)
                    state_next = BUSY_I;
            end
            BUSY_D: begin
                if (mem_ack) begin
                    if (i_avail)      state_next = BUSY_I;
                    else if (d_avail) state_next = BUSY_D;
                    else              state_next = IDLE;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    if (d_avail)      state_next = BUSY_D;
                    else if (i_avail) state_next = BUSY_I;
                    else              state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_d     = (state == BUSY_D) && mem_ack;
        ack_i     = (state == BUSY_I) && mem_ack;
        can_issue = (state == IDLE) || mem_ack;
        issue_d   = can_issue && (state_next == BUSY_D);
        issue_i   = can_issue && (state_next == BUSY_I);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_pend          <= 1'b0;
            d_slot_addr     <= '0;
            d_slot_write    <= 1'b0;
            d_slot_be       <= '0;
            d_slot_wdata    <= '0;
            i_pend          <= 1'b0;
            i_slot_addr     <= '0;
            last_grant_d    <= 1'b0;
            mem_request     <= 1'b0;
            mem_addr        <= '0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_wdata       <= '0;
            cpud_ack        <= 1'b0;
            cpud_rdata      <= '0;
            cpui_ack        <= 1'b0;
            cpui_rdata      <= '0;
            protocol_error  <= 1'b0;
        end else begin
            mem_request    <= issue_d || issue_i;
            cpud_ack       <= ack_d;
            cpui_ack       <= ack_i;
            protocol_error <= protocol_error || d_dup || i_dup;

            if (ack_d) cpud_rdata <= mem_rdata;
            if (ack_i) cpui_rdata <= mem_rdata;

            // A request arriving on the granting edge bypasses its slot.
            if (issue_d) begin
                mem_addr        <= d_pend ? d_slot_addr  : cpud_addr;
                mem_write       <= d_pend ? d_slot_write : cpud_write;
                mem_byte_enable <= d_pend ? d_slot_be    : cpud_byte_enable;
                mem_wdata       <= d_pend ? d_slot_wdata : cpud_wdata;
                last_grant_d    <= 1'b1;
            end else if (issue_i) begin
                mem_addr        <= i_pend ? i_slot_addr : cpui_addr;
                mem_write       <= 1'b0;
                mem_byte_enable <= 4'b1111;
                mem_wdata       <= '0;
                last_grant_d    <= 1'b0;
            end

            if (issue_d) begin
                d_pend <= 1'b0;
            end else if (d_new) begin
                d_pend       <= 1'b1;
                d_slot_addr  <= cpud_addr;
                d_slot_write <= cpud_write;
                d_slot_be    <= cpud_byte_enable;
                d_slot_wdata <= cpud_wdata;
            end

            if (issue_i) begin
                i_pend <= 1'b0;
            end else if (i_new) begin
                i_pend      <= 1'b1;
                i_slot_addr <= cpui_addr;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: one instance per arbitration mode, a transaction-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_cpu_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpud_request;
    logic [31:0] cpud_addr;
    logic        cpud_write;
    logic [3:0]  cpud_be;
    logic [31:0] cpud_wdata;
    logic        cpui_request;
    logic [31:0] cpui_addr;

    logic        mem_ack   [2] = '{1'b0, 1'b0};
    logic [31:0] mem_rdata [2] = '{32'h0, 32'h0};
    logic [31:0] cpud_rdata [2];
    logic        cpud_ack [2];
    logic [31:0] cpui_rdata [2];
    logic        cpui_ack [2];
    logic        mem_request [2];
    logic [31:0] mem_addr [2];
    logic        mem_write [2];
    logic [3:0]  mem_be [2];
    logic [31:0] mem_wdata [2];
    logic        perr [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // instance 0: data priority, instance 1: alternating
    for (genvar k = 0; k < 2; k++) begin : g_dut
        cpu_bus_arbiter #(.DATA_PRIORITY(k == 0 ? 1'b1 : 1'b0)) u_dut (
            .clock           (clock),
            .reset           (reset),
            .cpud_request    (cpud_request),
            .cpud_addr       (cpud_addr),
            .cpud_write      (cpud_write),
            .cpud_byte_enable(cpud_be),
            .cpud_wdata      (cpud_wdata),
            .cpud_rdata      (cpud_rdata[k]),
            .cpud_ack        (cpud_ack[k]),
            .cpui_request    (cpui_request),
            .cpui_addr       (cpui_addr),
            .cpui_rdata      (cpui_rdata[k]),
            .cpui_ack        (cpui_ack[k]),
            .mem_request     (mem_request[k]),
            .mem_addr        (mem_addr[k]),
            .mem_write       (mem_write[k]),
            .mem_byte_enable (mem_be[k]),
            .mem_wdata       (mem_wdata[k]),
            .mem_rdata       (mem_rdata[k]),
            .mem_ack         (mem_ack[k]),
            .protocol_error  (perr[k])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Memory responder: acks 'lat' cycles after each request; keeps counting through reset.
    int lat = 2;
    int cnt [2] = '{0, 0};
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            mem_ack[k] = 1'b0;
            if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) begin
                    mem_ack[k]   = 1'b1;
                    mem_rdata[k] = (mem_addr[k] == 32'hFFFF_0000) ? 32'h1234_5678 : ~mem_addr[k];
                end
            end
            if (mem_request[k] === 1'b1) cnt[k] = lat;
        end
    end

    // Transaction-level model: 0 = nothing in flight, 1 = data, 2 = fetch.
    int          m_inflight [2];
    bit          m_pd_v [2], m_pd_w [2], m_pi_v [2], m_last_d [2];
    logic [31:0] m_pd_a [2], m_pd_wd [2], m_pi_a [2];
    logic [3:0]  m_pd_be [2];
    logic        e_mreq [2], e_mwrite [2], e_dack [2], e_iack [2], e_perr [2];
    logic [31:0] e_maddr [2], e_mwdata [2], e_drdata [2], e_irdata [2];
    logic [3:0]  e_mbe [2];

    task automatic model_step(input int k);
        int acked;
        int pick;
        if (reset) begin
            m_inflight[k] = 0;  m_pd_v[k] = 0;  m_pi_v[k] = 0;  m_last_d[k] = 0;
            e_mreq[k] = 0;  e_maddr[k] = 0;  e_mwrite[k] = 0;  e_mbe[k] = 0;  e_mwdata[k] = 0;
            e_dack[k] = 0;  e_drdata[k] = 0; e_iack[k] = 0;    e_irdata[k] = 0; e_perr[k] = 0;
            return;
        end
        e_mreq[k] = 0;  e_dack[k] = 0;  e_iack[k] = 0;
        acked = 0;
        if (m_inflight[k] != 0 && mem_ack[k]) begin
            acked = m_inflight[k];
            if (acked == 1) begin e_dack[k] = 1; e_drdata[k] = mem_rdata[k]; end
            else            begin e_iack[k] = 1; e_irdata[k] = mem_rdata[k]; end
            m_inflight[k] = 0;
        end
        if (cpud_request) begin
            if (m_pd_v[k] || m_inflight[k] == 1) e_perr[k] = 1;
            else begin
                m_pd_v[k] = 1; m_pd_a[k] = cpud_addr; m_pd_w[k] = cpud_write;
                m_pd_be[k] = cpud_be; m_pd_wd[k] = cpud_wdata;
            end
        end
        if (cpui_request) begin
            if (m_pi_v[k] || m_inflight[k] == 2) e_perr[k] = 1;
            else begin m_pi_v[k] = 1; m_pi_a[k] = cpui_addr; end
        end
        if (m_inflight[k] == 0) begin
            pick = 0;
            if (m_pd_v[k] && m_pi_v[k]) begin
                if (acked == 1)      pick = 2;
                else if (acked == 2) pick = 1;
                else                 pick = (k == 0 || !m_last_d[k]) ? 1 : 2;
            end else if (m_pd_v[k]) pick = 1;
            else if (m_pi_v[k])     pick = 2;
            if (pick == 1) begin
                e_mreq[k] = 1; e_maddr[k] = m_pd_a[k]; e_mwrite[k] = m_pd_w[k];
                e_mbe[k] = m_pd_be[k]; e_mwdata[k] = m_pd_wd[k];
                m_pd_v[k] = 0; m_last_d[k] = 1; m_inflight[k] = 1;
            end else if (pick == 2) begin
                e_mreq[k] = 1; e_maddr[k] = m_pi_a[k]; e_mwrite[k] = 0;
                e_mbe[k] = 4'hF; e_mwdata[k] = 0;
                m_pi_v[k] = 0; m_last_d[k] = 0; m_inflight[k] = 2;
            end
        end
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("m_mem_request", k, 32'(mem_request[k]), 32'(e_mreq[k]));
            chk("m_mem_addr",    k, mem_addr[k],         e_maddr[k]);
            chk("m_mem_write",   k, 32'(mem_write[k]),   32'(e_mwrite[k]));
            chk("m_mem_be",      k, 32'(mem_be[k]),      32'(e_mbe[k]));
            chk("m_mem_wdata",   k, mem_wdata[k],        e_mwdata[k]);
            chk("m_cpud_ack",    k, 32'(cpud_ack[k]),    32'(e_dack[k]));
            chk("m_cpud_rdata",  k, cpud_rdata[k],       e_drdata[k]);
            chk("m_cpui_ack",    k, 32'(cpui_ack[k]),    32'(e_iack[k]));
            chk("m_cpui_rdata",  k, cpui_rdata[k],       e_irdata[k]);
            chk("m_perr",        k, 32'(perr[k]),        32'(e_perr[k]));
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
        cpud_request = 1'b0;
        cpui_request = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    logic [3:0] seq [2];
    int grants;
    int rereq;

    initial begin
        reset = 1'b1;
        cpud_request = 0; cpud_addr = 0; cpud_write = 0; cpud_be = 4'hF; cpud_wdata = 0;
        cpui_request = 0; cpui_addr = 0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_request", k, 32'(mem_request[k]), 32'h0);
            chk("rst_mem_addr",    k, mem_addr[k],         32'h0);
            chk("rst_mem_be",      k, 32'(mem_be[k]),      32'h0);
            chk("rst_perr",        k, 32'(perr[k]),        32'h0);
            chk("rst_cpui_rdata",  k, cpui_rdata[k],       32'h0);
        end
        reset = 1'b0;

        // single fetch
        lat = 2;
        step(); step();
        cpui_request = 1; cpui_addr = 32'hFFFF_0000;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("fetch_mem_request", k, 32'(mem_request[k]), 32'h1);
            chk("fetch_mem_addr",    k, mem_addr[k],         32'hFFFF_0000);
            chk("fetch_mem_write",   k, 32'(mem_write[k]),   32'h0);
            chk("fetch_mem_be",      k, 32'(mem_be[k]),      32'hF);
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("fetch_ack",   k, 32'(cpui_ack[k]), 32'h1);
            chk("fetch_rdata", k, cpui_rdata[k],    32'h1234_5678);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk("fetch_ack_pulse", k, 32'(cpui_ack[k]), 32'h0);
            chk("fetch_rdata_hold", k, cpui_rdata[k],   32'h1234_5678);
        end

        // simultaneous requests
        step();
        cpui_request = 1; cpui_addr = 32'h100;
        cpud_request = 1; cpud_addr = 32'h2000; cpud_write = 1; cpud_be = 4'b0011; cpud_wdata = 32'hDEAD_BEEF;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("sim_d_addr",  k, mem_addr[k],       32'h2000);
            chk("sim_d_write", k, 32'(mem_write[k]), 32'h1);
            chk("sim_d_be",    k, 32'(mem_be[k]),    32'h3);
            chk("sim_d_wdata", k, mem_wdata[k],      32'hDEAD_BEEF);
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("sim_d_ack",     k, 32'(cpud_ack[k]),    32'h1);
            chk("sim_d_rdata",   k, cpud_rdata[k],       32'hFFFF_DFFF);
            chk("sim_i_request", k, 32'(mem_request[k]), 32'h1);
            chk("sim_i_addr",    k, mem_addr[k],         32'h100);
            chk("sim_i_be",      k, 32'(mem_be[k]),      32'hF);
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("sim_i_ack",   k, 32'(cpui_ack[k]), 32'h1);
            chk("sim_i_rdata", k, cpui_rdata[k],    32'hFFFF_FEFF);
        end
        step();

        // alternation: re-request each bus on its own ack cycle
        cpud_write = 0; cpud_be = 4'hF; cpud_wdata = 0;
        step();
        cpud_request = 1; cpud_addr = 32'h2100;
        cpui_request = 1; cpui_addr = 32'h140;
        seq[0] = 0; seq[1] = 0; grants = 0; rereq = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            step();
            if (mem_request[0]) seq[0] = {seq[0][2:0], mem_addr[0][13]};
            if (mem_request[1]) begin seq[1] = {seq[1][2:0], mem_addr[1][13]}; grants++; end
            if (mem_ack[0] && rereq < 2) begin
                if (mem_addr[0][13]) begin cpud_request = 1; cpud_addr = 32'h2200; end
                else                 begin cpui_request = 1; cpui_addr = 32'h180;  end
                rereq++;
            end
        end
        chk("alt_grant_count", 1, 32'(grants), 32'd4);
        chk("alt_order_dp0", 1, 32'(seq[1]), 32'b1010);
        chk("alt_order_dp1", 0, 32'(seq[0]), 32'b1010);
        repeat (6) step();

        // duplicate request while data in flight
        lat = 3;
        step();
        cpud_request = 1; cpud_addr = 32'h2400;
        step();
        cpud_request = 1; cpud_addr = 32'h2800;
        step();
        for (int k = 0; k < 2; k++) chk("dup_perr_set", k, 32'(perr[k]), 32'h1);
        for (int c = 0; c < 8; c++) begin
            step();
            for (int k = 0; k < 2; k++)
                chk("dup_not_issued", k, 32'(mem_request[k] && mem_addr[k] == 32'h2800), 32'h0);
        end
        for (int k = 0; k < 2; k++) chk("dup_perr_sticky", k, 32'(perr[k]), 32'h1);
        reset = 1;
        step(); step();
        reset = 0;
        for (int k = 0; k < 2; k++) chk("dup_perr_cleared", k, 32'(perr[k]), 32'h0);

        // reset mid-transaction, stray ack afterwards
        step();
        cpui_request = 1; cpui_addr = 32'h500;
        step();
        for (int k = 0; k < 2; k++) chk("rmid_mem_request", k, 32'(mem_request[k]), 32'h1);
        step();
        reset = 1;
        step();
        reset = 0;
        for (int k = 0; k < 2; k++) chk("rmid_addr_cleared", k, mem_addr[k], 32'h0);
        step(); step();
        for (int k = 0; k < 2; k++) begin
            chk("rmid_no_iack", k, 32'(cpui_ack[k]), 32'h0);
            chk("rmid_no_dack", k, 32'(cpud_ack[k]), 32'h0);
            chk("rmid_perr",    k, 32'(perr[k]),     32'h0);
        end
        step();
        lat = 1;
        cpui_request = 1; cpui_addr = 32'h600;
        step();
        for (int k = 0; k < 2; k++) chk("rmid_new_addr", k, mem_addr[k], 32'h600);
        step(); step();
        for (int k = 0; k < 2; k++) begin
            chk("rmid_new_ack",   k, 32'(cpui_ack[k]), 32'h1);
            chk("rmid_new_rdata", k, cpui_rdata[k],    32'hFFFF_F9FF);
        end

        // data request in the same cycle as the data ack
        lat = 2;
        step();
        cpud_request = 1; cpud_addr = 32'h2C00;
        repeat (3) step();
        cpud_request = 1; cpud_addr = 32'h3000;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("ackreq_dack",     k, 32'(cpud_ack[k]),    32'h1);
            chk("ackreq_drdata",   k, cpud_rdata[k],       32'hFFFF_D3FF);
            chk("ackreq_mem_req",  k, 32'(mem_request[k]), 32'h1);
            chk("ackreq_mem_addr", k, mem_addr[k],         32'h3000);
            chk("ackreq_perr",     k, 32'(perr[k]),        32'h0);
        end
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
